// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared types and constants for the fetch stage
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

    // B-immediate is a half-word offset: append the implicit zero and sign-extend 13 -> 32 bits
    function automatic logic [31:0] sext_b_offset(input logic [11:0] b_imm);
        return {{19{b_imm[11]}}, b_imm, 1'b0};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch stage bus between branch unit, instruction memory and decode
interface pc_fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [11:0] b_imm;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ins_mem_rw;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic        fault;

    modport master (
        input  stall, branch_taken, branch_pc, b_imm, instr,
        output pc, ins_mem_rw, if_instr, if_pc, if_valid, halted, fault
    );

    modport slave (
        output stall, branch_taken, branch_pc, b_imm, instr,
        input  pc, ins_mem_rw, if_instr, if_pc, if_valid, halted, fault
    );
endinterface

// File: rtl/pc_fetch_unit_branch_target_calc.sv
// rtl/pc_fetch_unit_branch_target_calc.sv - branch target adder and alignment check
module branch_target_calc
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] i_branch_pc,
    input  logic [11:0] i_b_imm,
    output logic [31:0] o_target,
    output logic        o_misaligned
);

    // Wrapping 32-bit add; any set bit in [1:0] means the target is not word aligned
    always_comb begin
        o_target     = i_branch_pc + sext_b_offset(i_b_imm);
        o_misaligned = |o_target[1:0];
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, IF/ID register and next-PC selection
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.master bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_if_instr;
    logic [31:0]  w_if_instr_nxt;
    logic [31:0]  r_if_pc;
    logic [31:0]  w_if_pc_nxt;
    logic         r_if_valid;
    logic         w_if_valid_nxt;
    logic [31:0]  w_target;
    logic         w_misaligned;

    branch_target_calc u_target (
        .i_branch_pc  (bus.branch_pc),
        .i_b_imm      (bus.b_imm),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    // Next-state selection: branch beats stall beats normal fetch; HALT/FAULT only drain if_valid
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;
        w_if_valid_nxt = r_if_valid;
        case (r_state)
            RUN: begin
                if (bus.branch_taken) begin
                    w_if_valid_nxt = 1'b0;
                    if (w_misaligned) begin
                        w_state_nxt = FAULT;
                    end else begin
                        w_pc_nxt = w_target;
                    end
                end else if (!bus.stall) begin
                    if (bus.instr == HALT_WORD) begin
                        w_state_nxt    = HALT;
                        w_if_valid_nxt = 1'b0;
                    end else begin
                        w_if_instr_nxt = bus.instr;
                        w_if_pc_nxt    = r_pc;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = r_pc + PC_STEP;
                    end
                end
            end
            HALT, FAULT: begin
                w_if_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt    = FAULT;
                w_if_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID registers; reset overrides any redirect or stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_if_instr <= 32'h0;
            r_if_pc    <= 32'h0;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

    // Status flags decode straight from the state so halted and fault can never overlap
    always_comb begin
        bus.pc         = r_pc;
        bus.if_instr   = r_if_instr;
        bus.if_pc      = r_if_pc;
        bus.if_valid   = r_if_valid;
        bus.ins_mem_rw = (r_state == RUN);
        bus.halted     = (r_state == HALT);
        bus.fault      = (r_state == FAULT);
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for the fetch stage
module tb_pc_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] if_instr;
        logic [31:0] if_pc;
        logic        if_valid;
        logic        halted;
        logic        fault;
        logic        rw;
    } exp_t;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    pc_fetch_unit_if bus();

    pc_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // reference model: 0=run 1=halt 2=fault
    int          m_state = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ii = 32'h0;
    logic [31:0] m_ip = 32'h0;
    logic        m_v  = 1'b0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    task automatic step(input logic rst, input logic st, input logic bt,
                        input logic [31:0] bpc, input logic [11:0] bimm,
                        input logic [31:0] iw);
        logic [31:0] tgt;
        exp_t        e;
        reset            = rst;
        bus.stall        = st;
        bus.branch_taken = bt;
        bus.branch_pc    = bpc;
        bus.b_imm        = bimm;
        bus.instr        = iw;
        tgt = bpc + {{19{bimm[11]}}, bimm, 1'b0};
        if (rst) begin
            m_state = 0; m_pc = 32'h0; m_ii = 32'h0; m_ip = 32'h0; m_v = 1'b0;
        end else if (m_state == 0) begin
            if (bt) begin
                m_v = 1'b0;
                if (tgt[1:0] != 2'b00) m_state = 2;
                else m_pc = tgt;
            end else if (!st) begin
                if (iw == HALT_W) begin
                    m_state = 1; m_v = 1'b0;
                end else begin
                    m_ii = iw; m_ip = m_pc; m_v = 1'b1; m_pc = m_pc + 32'd4;
                end
            end
        end else begin
            m_v = 1'b0;
        end
        e.pc = m_pc; e.if_instr = m_ii; e.if_pc = m_ip; e.if_valid = m_v;
        e.halted = (m_state == 1); e.fault = (m_state == 2); e.rw = (m_state == 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0, 1:    step(1, 1, 1, 32'h40, 12'h004, 32'h0);
                2:       step(0, 0, 0, 0, 0, word_at(m_pc));
                default: step(0, 0, 0, 0, 0, 32'h00808113);
            endcase
            n_tests++;
            o = {bus.pc, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.fault, bus.ins_mem_rw};
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %h want %h", k, o, e);
            end
            if (k == 1) begin
                n_tests++;
                if (bus.pc !== 32'h0 || bus.ins_mem_rw !== 1'b1 || bus.if_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_state: got pc=%h rw=%b v=%b want pc=0 rw=1 v=0", bus.pc, bus.ins_mem_rw, bus.if_valid);
                end
            end
        end
        n_tests++;
        if (bus.if_instr !== 32'h00808113 || bus.if_pc !== 32'h4 || bus.pc !== 32'h8 || bus.if_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fetch: got ii=%h ip=%h pc=%h v=%b want 00808113/4/8/1", bus.if_instr, bus.if_pc, bus.pc, bus.if_valid);
        end
    endtask

    task automatic test_sequential();
        exp_t e, o;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) step(1, 0, 0, 0, 0, 32'h0);
            else        step(0, 0, 0, 0, 0, word_at(m_pc));
            n_tests++;
            o = {bus.pc, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.fault, bus.ins_mem_rw};
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if (o !== e) begin
                n_fail++;
                $display("FAIL seq[%0d]: got %h want %h", k, o, e);
            end
        end
        n_tests++;
        if (bus.pc !== 32'h14 || bus.if_pc !== 32'h10) begin
            n_fail++;
            $display("FAIL seq_end: got pc=%h if_pc=%h want 14/10", bus.pc, bus.if_pc);
        end
    endtask

    task automatic test_stall();
        exp_t e, o;
        for (int k = 0; k < 7; k++) begin
            case (k)
                0:          step(1, 0, 0, 0, 0, 32'h0);
                3, 4, 5:    step(0, 1, 0, 0, 0, 32'h1234_5673);
                default:    step(0, 0, 0, 0, 0, word_at(m_pc));
            endcase
            n_tests++;
            o = {bus.pc, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.fault, bus.ins_mem_rw};
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %h want %h", k, o, e);
            end
        end
        n_tests++;
        if (bus.pc !== 32'hC) begin
            n_fail++;
            $display("FAIL stall_release: got pc=%h want c", bus.pc);
        end
    endtask

    task automatic test_branch();
        exp_t e, o;
        for (int k = 0; k < 6; k++) begin
            case (k)
                0:       step(1, 0, 0, 0, 0, 32'h0);
                4:       step(0, 1, 1, 32'hC, 12'h004, word_at(m_pc));
                5:       step(0, 0, 1, 32'h10, 12'hFFE, word_at(m_pc));
                default: step(0, 0, 0, 0, 0, word_at(m_pc));
            endcase
            n_tests++;
            o = {bus.pc, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.fault, bus.ins_mem_rw};
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if (o !== e) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %h want %h", k, o, e);
            end
            if (k == 4) begin
                n_tests++;
                if (bus.pc !== 32'h14 || bus.if_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL branch_fwd: got pc=%h v=%b want 14/0", bus.pc, bus.if_valid);
                end
            end
        end
        n_tests++;
        if (bus.pc !== 32'hC) begin
            n_fail++;
            $display("FAIL branch_back: got pc=%h want c", bus.pc);
        end
    endtask

    task automatic test_fault();
        exp_t e, o;
        for (int k = 0; k < 9; k++) begin
            case (k)
                0, 8:    step(1, 0, 0, 0, 0, 32'h0);
                4:       step(0, 0, 1, 32'hC, 12'h001, word_at(m_pc));
                5:       step(0, 0, 1, 32'hC, 12'h004, word_at(m_pc));
                6:       step(0, 1, 0, 0, 0, word_at(m_pc));
                7:       step(0, 0, 0, 0, 0, word_at(m_pc));
                default: step(0, 0, 0, 0, 0, word_at(m_pc));
            endcase
            n_tests++;
            o = {bus.pc, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.fault, bus.ins_mem_rw};
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if (o !== e) begin
                n_fail++;
                $display("FAIL fault[%0d]: got %h want %h", k, o, e);
            end
            if (k == 7) begin
                n_tests++;
                if (bus.fault !== 1'b1 || bus.pc !== 32'hC || bus.ins_mem_rw !== 1'b0 || bus.halted !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fault_hold: got f=%b pc=%h rw=%b h=%b want 1/c/0/0", bus.fault, bus.pc, bus.ins_mem_rw, bus.halted);
                end
            end
        end
        n_tests++;
        if (bus.pc !== 32'h0 || bus.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_reset: got pc=%h f=%b want 0/0", bus.pc, bus.fault);
        end
    endtask

    task automatic test_halt_wrap();
        exp_t e, o;
        for (int k = 0; k < 21; k++) begin
            if (k == 0 || k == 17)  step(1, 0, 0, 0, 0, 32'h0);
            else if (k == 13)       step(0, 0, 0, 0, 0, HALT_W);
            else if (k > 13 && k < 17) step(0, k == 15, k == 14, 32'h0, 12'h008, word_at(m_pc));
            else if (k == 18)       step(0, 0, 1, 32'h0, 12'hFFE, word_at(m_pc));
            else                    step(0, 0, 0, 0, 0, word_at(m_pc));
            n_tests++;
            o = {bus.pc, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.fault, bus.ins_mem_rw};
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if (o !== e) begin
                n_fail++;
                $display("FAIL halt[%0d]: got %h want %h", k, o, e);
            end
            if (k == 16) begin
                n_tests++;
                if (bus.halted !== 1'b1 || bus.pc !== 32'h30 || bus.if_valid !== 1'b0 || bus.ins_mem_rw !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt_hold: got h=%b pc=%h v=%b rw=%b want 1/30/0/0", bus.halted, bus.pc, bus.if_valid, bus.ins_mem_rw);
                end
            end
            if (k == 18) begin
                n_tests++;
                if (bus.pc !== 32'hFFFF_FFFC) begin
                    n_fail++;
                    $display("FAIL wrap_setup: got pc=%h want fffffffc", bus.pc);
                end
            end
        end
        n_tests++;
        if (bus.pc !== 32'h4 || bus.if_pc !== 32'h0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap: got pc=%h if_pc=%h h=%b want 4/0/0", bus.pc, bus.if_pc, bus.halted);
        end
    endtask

    task automatic test_random();
        exp_t e, o;
        logic [11:0] imm;
        for (int k = 0; k < 60; k++) begin
            imm = 12'($urandom_range(0, 63));
            if ($urandom_range(0, 9) != 0) imm[0] = 1'b0;
            if (k == 0 || k == 30) step(1, 0, 0, 0, 0, 32'h0);
            else step(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), m_pc, imm,
                      ($urandom_range(0, 40) == 0) ? HALT_W : word_at(m_pc));
            n_tests++;
            o = {bus.pc, bus.if_instr, bus.if_pc, bus.if_valid, bus.halted, bus.fault, bus.ins_mem_rw};
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", k, o, e);
            end
        end
    endtask

    initial begin
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_pc = 32'h0;
        bus.b_imm = 12'h0; bus.instr = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_fault();
        test_halt_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
